// File: rtl/pacman_scoreboard_if.sv
// ============================================================================
// Module      : pacman_scoreboard_if
// Description : Bundles the scoreboard's board inputs and its HUD/status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pacman_scoreboard_if #(
    parameter int WIDTH   = 8,
    parameter int HEIGHT  = 8,
    parameter int SCORE_W = 16,
    parameter int TIMER_W = 16,
    parameter int CNT_W   = $clog2(WIDTH*HEIGHT+1)
);
    logic [WIDTH-1:0][HEIGHT-1:0] candies;
    logic                         catch;
    logic [SCORE_W-1:0]           score;
    logic [CNT_W-1:0]             candies_left;
    logic [TIMER_W-1:0]           time_left;
    logic [1:0]                   state;
    logic                         eat_pulse;
    logic                         game_over;

    modport master (
        output candies, catch,
        input  score, candies_left, time_left, state, eat_pulse, game_over
    );

    modport slave (
        input  candies, catch,
        output score, candies_left, time_left, state, eat_pulse, game_over
    );
endinterface

`default_nettype wire

// File: rtl/pacman_scoreboard.sv
// ============================================================================
// Module      : pacman_scoreboard
// Description : Score, candy count, countdown timer and win/lose FSM for the Pac-Man grid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pacman_scoreboard #(
    parameter int WIDTH      = 8,
    parameter int HEIGHT     = 8,
    parameter int SCORE_W    = 16,
    parameter int POINTS     = 10,
    parameter int TIMER_W    = 16,
    parameter int TIME_LIMIT = 1000,
    parameter int CNT_W      = $clog2(WIDTH*HEIGHT+1)
) (
    input  wire logic          clk,
    input  wire logic          reset,
    pacman_scoreboard_if.slave bus
);

    localparam int N     = WIDTH * HEIGHT;
    localparam int SUM_W = SCORE_W + CNT_W + $clog2(POINTS + 1);

    localparam logic [SUM_W-1:0]   c_score_max  = SUM_W'({SCORE_W{1'b1}});
    localparam logic [SUM_W-1:0]   c_points     = SUM_W'(POINTS);
    localparam logic [TIMER_W-1:0] c_time_limit = TIMER_W'(TIME_LIMIT);
    localparam bit                 c_timer_on   = (TIME_LIMIT != 0);

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_PLAY = 2'b01,
        ST_WON  = 2'b10,
        ST_LOST = 2'b11
    } state_t;

    state_t             r_state;
    logic [N-1:0]       r_prev;
    logic [SCORE_W-1:0] r_score;
    logic [CNT_W-1:0]   r_left;
    logic [TIMER_W-1:0] r_time;
    logic               r_pulse;
    logic               r_over;

    logic [N-1:0]       w_cur;
    logic [CNT_W-1:0]   w_eaten;
    logic [CNT_W-1:0]   w_load_cnt;
    logic [SUM_W-1:0]   w_sum;
    logic [SCORE_W-1:0] w_score_next;
    logic [CNT_W-1:0]   w_left_next;
    logic [TIMER_W-1:0] w_time_next;
    logic               w_timeout;
    state_t             w_play_next;

    function automatic logic [CNT_W-1:0] popcount(input logic [N-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    assign w_cur      = bus.candies;
    // Only 1->0 transitions count as eats; a candy reappearing is ignored.
    assign w_eaten    = popcount(r_prev & ~w_cur);
    assign w_load_cnt = popcount(w_cur);

    assign w_sum        = SUM_W'(r_score) + c_points * SUM_W'(w_eaten);
    assign w_score_next = (w_sum > c_score_max) ? {SCORE_W{1'b1}} : w_sum[SCORE_W-1:0];
    assign w_left_next  = (w_eaten >= r_left) ? '0 : (r_left - w_eaten);
    assign w_time_next  = (c_timer_on && (r_time != '0)) ? (r_time - 1'b1) : r_time;
    assign w_timeout    = c_timer_on && (r_time == TIMER_W'(1));

    // Catch beats a cleared board, which beats the timeout.
    always_comb begin
        w_play_next = ST_PLAY;
        if (bus.catch) begin
            w_play_next = ST_LOST;
        end else if (w_left_next == '0) begin
            w_play_next = ST_WON;
        end else if (w_timeout) begin
            w_play_next = ST_LOST;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_LOAD;
            r_prev  <= '0;
            r_score <= '0;
            r_left  <= '0;
            r_time  <= c_time_limit;
            r_pulse <= 1'b0;
            r_over  <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_prev  <= w_cur;
                    r_left  <= w_load_cnt;
                    r_time  <= c_time_limit;
                    r_state <= ST_PLAY;
                end
                ST_PLAY: begin
                    r_prev  <= w_cur;
                    r_score <= w_score_next;
                    r_left  <= w_left_next;
                    r_time  <= w_time_next;
                    r_state <= w_play_next;
                    // The pulse is suppressed on the edge that ends the game.
                    r_pulse <= (w_eaten != '0) && (w_play_next == ST_PLAY);
                    r_over  <= (w_play_next != ST_PLAY);
                end
                default: begin
                    r_pulse <= 1'b0;
                end
            endcase
        end
    end

    assign bus.score        = r_score;
    assign bus.candies_left = r_left;
    assign bus.time_left    = r_time;
    assign bus.state        = r_state;
    assign bus.eat_pulse    = r_pulse;
    assign bus.game_over    = r_over;

endmodule

`default_nettype wire

// File: tb/tb_pacman_scoreboard.sv
// ============================================================================
// Module      : tb_pacman_scoreboard
// Description : Self-checking bench: table-driven main game plus timer, saturation and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pacman_scoreboard;

    logic clk;
    logic rst_a, rst_t, rst_s;
    int   n_tests = 0;
    int   n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pacman_scoreboard_if #(.SCORE_W(16)) ifa ();
    pacman_scoreboard_if #(.SCORE_W(16)) ift ();
    pacman_scoreboard_if #(.SCORE_W(8))  ifs ();

    pacman_scoreboard dut_a (.clk(clk), .reset(rst_a), .bus(ifa.slave));
    pacman_scoreboard #(.TIME_LIMIT(5)) dut_t (.clk(clk), .reset(rst_t), .bus(ift.slave));
    pacman_scoreboard #(.SCORE_W(8), .POINTS(100)) dut_s (.clk(clk), .reset(rst_s), .bus(ifs.slave));

    typedef struct {
        logic [15:0] score;
        logic [6:0]  left;
        logic [15:0] time_left;
        logic [1:0]  state;
        logic        pulse;
        logic        over;
    } exp_t;

    typedef struct {
        logic [63:0] candies;
        logic        catch;
        exp_t        exp;
    } vec_t;

    vec_t vecs[8];
    exp_t sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input exp_t e);
        chk({tag, " score"},     32'(ifa.score),        32'(e.score));
        chk({tag, " left"},      32'(ifa.candies_left), 32'(e.left));
        chk({tag, " time_left"}, 32'(ifa.time_left),    32'(e.time_left));
        chk({tag, " state"},     32'(ifa.state),        32'(e.state));
        chk({tag, " eat_pulse"}, 32'(ifa.eat_pulse),    32'(e.pulse));
        chk({tag, " game_over"}, 32'(ifa.game_over),    32'(e.over));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        vecs[0] = '{64'h0000_0000_7FFF_FFFF, 1'b0, '{16'd0,   7'd31, 16'd1000, 2'd1, 1'b0, 1'b0}};
        vecs[1] = '{64'h0000_0000_7FFF_FDFF, 1'b0, '{16'd10,  7'd30, 16'd999,  2'd1, 1'b1, 1'b0}};
        vecs[2] = '{64'h0000_0000_7FFF_FDFF, 1'b0, '{16'd10,  7'd30, 16'd998,  2'd1, 1'b0, 1'b0}};
        vecs[3] = '{64'h0000_0000_7FFF_FDFC, 1'b0, '{16'd30,  7'd28, 16'd997,  2'd1, 1'b1, 1'b0}};
        vecs[4] = '{64'h0000_0000_7FFF_FDFD, 1'b0, '{16'd30,  7'd28, 16'd996,  2'd1, 1'b0, 1'b0}};
        vecs[5] = '{64'h0000_0000_0000_0005, 1'b0, '{16'd300, 7'd1,  16'd995,  2'd1, 1'b1, 1'b0}};
        vecs[6] = '{64'h0000_0000_0000_0001, 1'b1, '{16'd310, 7'd0,  16'd994,  2'd3, 1'b0, 1'b1}};
        vecs[7] = '{64'h0000_0000_0000_0000, 1'b0, '{16'd310, 7'd0,  16'd994,  2'd3, 1'b0, 1'b1}};

        rst_a = 1'b1; rst_t = 1'b1; rst_s = 1'b1;
        ifa.candies = '0; ifa.catch = 1'b0;
        ift.candies = '0; ift.catch = 1'b0;
        ifs.candies = '0; ifs.catch = 1'b0;
        step();
        step();
        chk_a("reset", '{16'd0, 7'd0, 16'd1000, 2'd0, 1'b0, 1'b0});
        rst_a = 1'b0;

        // Main game: each vector is applied for one edge, its expectation
        // queued on drive and retired once the edge has been taken.
        for (int i = 0; i < 8; i++) begin
            ifa.candies = vecs[i].candies;
            ifa.catch   = vecs[i].catch;
            sb_q.push_back(vecs[i].exp);
            step();
            e = sb_q.pop_front();
            chk_a($sformatf("vec%0d", i), e);
        end

        // Timeout with no eats: five PLAY edges reach LOST with time_left 0.
        rst_t = 1'b0;
        ift.candies = 64'h3;
        step();
        chk("t load time", 32'(ift.time_left), 32'd5);
        chk("t load state", 32'(ift.state), 32'd1);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("t time %0d", k), 32'(ift.time_left), 32'(5 - k));
            chk($sformatf("t state %0d", k), 32'(ift.state), (k < 5) ? 32'd1 : 32'd3);
        end
        chk("t game_over", 32'(ift.game_over), 32'd1);
        step();
        chk("t frozen time", 32'(ift.time_left), 32'd0);

        // Last candy eaten on the timeout edge wins.
        rst_t = 1'b1;
        step();
        rst_t = 1'b0;
        ift.candies = 64'h1;
        step();
        for (int k = 1; k <= 4; k++) step();
        chk("tw state pre", 32'(ift.state), 32'd1);
        ift.candies = 64'h0;
        step();
        chk("tw state", 32'(ift.state), 32'd2);
        chk("tw time", 32'(ift.time_left), 32'd0);
        chk("tw score", 32'(ift.score), 32'd10);
        chk("tw game_over", 32'(ift.game_over), 32'd1);
        chk("tw eat_pulse", 32'(ift.eat_pulse), 32'd0);

        // Empty board: LOAD gives zero candies, first PLAY edge wins.
        rst_t = 1'b1;
        step();
        rst_t = 1'b0;
        ift.candies = 64'h0;
        step();
        chk("empty load state", 32'(ift.state), 32'd1);
        chk("empty load left", 32'(ift.candies_left), 32'd0);
        step();
        chk("empty state", 32'(ift.state), 32'd2);

        // Saturation at SCORE_W=8, POINTS=100.
        rst_s = 1'b0;
        ifs.candies = 64'hF;
        step();
        ifs.candies = 64'hE;
        step();
        chk("s score1", 32'(ifs.score), 32'd100);
        ifs.candies = 64'hC;
        step();
        chk("s score2", 32'(ifs.score), 32'd200);
        ifs.candies = 64'h8;
        step();
        chk("s score3", 32'(ifs.score), 32'd255);
        chk("s left3", 32'(ifs.candies_left), 32'd1);
        chk("s state3", 32'(ifs.state), 32'd1);

        // Mid-cycle reset takes effect without waiting for a clock edge.
        #2;
        rst_s = 1'b1;
        #1;
        chk("async state", 32'(ifs.state), 32'd0);
        chk("async score", 32'(ifs.score), 32'd0);
        chk("async left", 32'(ifs.candies_left), 32'd0);
        chk("async time", 32'(ifs.time_left), 32'd1000);
        chk("async pulse", 32'(ifs.eat_pulse), 32'd0);
        chk("async over", 32'(ifs.game_over), 32'd0);
        step();
        rst_s = 1'b0;
        ifs.candies = 64'hFF;
        step();
        chk("reload state", 32'(ifs.state), 32'd1);
        chk("reload left", 32'(ifs.candies_left), 32'd8);
        chk("reload score", 32'(ifs.score), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pacman_scoreboard.md
Name: pacman_scoreboard

Overview:
Downstream game-status stage for the Pac-Man grid block. It consumes the candy bitmap and catch flag, and produces:
- score and remaining-candy count;
- a per-eat pulse;
- a countdown timer;
- the game outcome FSM (LOAD/PLAY/WON/LOST).

Its outputs drive display/HUD logic and the top-level game-over handling.

Parameters:
WIDTH, 8, grid width; must match the game block.
HEIGHT, 8, grid height; must match the game block.
SCORE_W, 16, score register width.
POINTS, 10, points added per candy eaten.
TIMER_W, 16, countdown timer width.
TIME_LIMIT, 1000, PLAY cycles allowed before timeout; 0 disables the timer.
CNT_W, $clog2(WIDTH*HEIGHT+1), width of candy counters.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
candies  input  [WIDTH-1:0][HEIGHT-1:0]  candy bitmap from the game block (1 = candy present)
catch  input  1  sticky ghost-caught-Pac-Man flag from the game block
score  output  SCORE_W  accumulated score
candies_left  output  CNT_W  candies remaining
time_left  output  TIMER_W  remaining PLAY cycles
state  output  2  00=LOAD, 01=PLAY, 10=WON, 11=LOST
eat_pulse  output  1  one-cycle pulse; 1 in the cycle after any candy was eaten
game_over  output  1  1 when state is WON or LOST

Behaviour:
- Reset: reset is asynchronous and active-high; clock is clk. All state is registered.
  - Reset values: state=LOAD, score=0, candies_left=0, time_left=TIME_LIMIT, eat_pulse=0, game_over=0, prev_candies=0.
  - Reset asserted mid-game returns every output to its reset value immediately.
- LOAD lasts exactly one clk edge after reset deasserts. On that edge:
  - prev_candies <= candies;
  - candies_left <= popcount(candies);
  - time_left <= TIME_LIMIT;
  - state <= PLAY.
- PLAY, each edge:
  - eaten = popcount(prev_candies & ~candies) (CNT_W wide; normally 0 or 1, any count supported).
  - prev_candies <= candies.
  - Bits that go 0->1 are ignored: no score change, no candies_left change.
- Score: score <= score + POINTS*eaten.
  - Computed at SCORE_W+CNT_W+$clog2(POINTS+1) bits, then saturated to 2^SCORE_W-1.
  - Once saturated, score holds at max.
- Candy count: candies_left <= candies_left - eaten, floored at 0.
- eat_pulse <= (eaten != 0).
  - Latency: a bit cleared in candies at edge N shows its score update and eat_pulse after edge N+1.
- Timer: if TIME_LIMIT != 0, time_left <= time_left - 1 on every PLAY edge.
- Transitions out of PLAY, evaluated on the same edge, in priority order:
  1. catch==1 -> LOST.
  2. Else the post-update candies_left==0 -> WON.
  3. Else TIME_LIMIT!=0 and time_left==1 (reaching 0) -> LOST.
  4. Otherwise stay in PLAY.
- Simultaneous events:
  - Last candy eaten in the same cycle catch is seen -> LOST. Score and candies_left still take that final update.
  - Last candy eaten on the timeout edge -> WON.
  - Timeout leaves time_left=0 in LOST.
- WON/LOST are terminal until reset:
  - score, candies_left and time_left are frozen;
  - eat_pulse=0 from the first terminal cycle onward;
  - candies and catch are ignored;
  - game_over=1 (registered, coincident with the state change).
- Empty board at LOAD: popcount=0 gives candies_left=0; the first PLAY edge goes to WON, or to LOST if catch=1.

Test Plan:
1. Reset, then drive a 31-bit candy bitmap -> after the LOAD edge: state=PLAY, candies_left=31, score=0, time_left=1000.
2. In PLAY, clear candies[1][1] -> one edge later: score=10, candies_left=30, eat_pulse=1 for exactly one cycle; next cycle eat_pulse=0.
3. Clear two bits in the same cycle -> score +20, candies_left -2. Re-set one of those bits -> no change to any counter.
4. candies_left=1: clear the last bit and assert catch on the same cycle -> state=LOST, candies_left=0, score includes +10, game_over=1. Further clears -> score unchanged.
5. TIME_LIMIT=5, no eats -> after 5 PLAY edges: state=LOST, time_left=0. Repeat with the last candy eaten on edge 5 -> state=WON.
6. SCORE_W=8, POINTS=100, three eats -> score=255 (saturated). Assert reset mid-PLAY -> all outputs return to reset values asynchronously, and LOAD is repeated.
